// File: rtl/papsel_dispense_ctrl.sv
// Paper-feeder / change-hopper sequencer: queues vend orders and serves each one
// (one sheet, then greedy 2/1-unit coins). Build option: PAPSEL_ORDER_CNT_EN adds ord_cnt/flt_cnt.
module papsel_dispense_ctrl #(
    parameter int DEPTH        = 4,
    parameter int FEED_TIMEOUT = 255,
    parameter int TO_W         = 8
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       ord_vld,
    input  logic [2:0] ord_chg,
    output logic       ord_rdy,
    output logic       ord_ovf,
    output logic       feed_req,
    input  logic       feed_ack,
    output logic       coin_req,
    output logic [1:0] coin_val,
    input  logic       coin_ack,
    output logic       busy,
    output logic       done,
    output logic       fault,
    input  logic       fault_clr
`ifdef PAPSEL_ORDER_CNT_EN
    ,
    output logic [15:0] ord_cnt,
    output logic [7:0]  flt_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FEED  = 3'd1,
        PAY   = 3'd2,
        GAP   = 3'd3,
        DONE  = 3'd4,
        FAULT = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      rem_q, rem_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic [2:0]      fifo_mem_q [DEPTH];

    logic            full, empty, push, pop, to_hit;
    logic [1:0]      coin_val_w;

    assign full   = (count_q == CW'(DEPTH));
    assign empty  = (count_q == '0);
    assign push   = ord_vld && !full;
    assign to_hit = (to_cnt_q == TO_W'(FEED_TIMEOUT - 1));

    // Coin value depends only on rem_q, which changes only when leaving PAY,
    // so it stays stable for the whole request.
    assign coin_val_w = (state_q == PAY) ? ((rem_q >= 3'd2) ? 2'd2 : 2'd1) : 2'd0;

    assign ord_rdy  = !full;
    assign ord_ovf  = ovf_q;
    assign feed_req = (state_q == FEED);
    assign coin_req = (state_q == PAY);
    assign coin_val = coin_val_w;
    assign busy     = (state_q != IDLE) || !empty;
    assign done     = (state_q == DONE);
    assign fault    = (state_q == FAULT);

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        to_cnt_d = to_cnt_q;
        pop      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    rem_d    = fifo_mem_q[rd_ptr_q];
                    to_cnt_d = '0;
                    state_d  = FEED;
                end
            end
            FEED: begin
                to_cnt_d = to_cnt_q + TO_W'(1);
                // An ack landing on the timeout cycle still completes the feed.
                if (feed_ack) begin
                    state_d = (rem_q != 3'd0) ? PAY : DONE;
                end else if (to_hit) begin
                    state_d = FAULT;
                    rem_d   = '0;
                end
            end
            PAY: begin
                if (coin_ack) begin
                    rem_d   = rem_q - {1'b0, coin_val_w};
                    state_d = GAP;
                end
            end
            GAP:     state_d = (rem_q != 3'd0) ? PAY : DONE;
            DONE:    state_d = IDLE;
            FAULT:   if (fault_clr) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        ovf_d    = ord_vld && full;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            to_cnt_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            to_cnt_q <= to_cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= ord_chg;
        end
    end

`ifdef PAPSEL_ORDER_CNT_EN
    logic [15:0] ord_cnt_q, ord_cnt_d;
    logic [7:0]  flt_cnt_q, flt_cnt_d;

    always_comb begin
        ord_cnt_d = (state_q == DONE) ? ord_cnt_q + 16'd1 : ord_cnt_q;
        flt_cnt_d = flt_cnt_q;
        if (state_q != FAULT && state_d == FAULT && flt_cnt_q != 8'hFF) begin
            flt_cnt_d = flt_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ord_cnt_q <= '0;
            flt_cnt_q <= '0;
        end else begin
            ord_cnt_q <= ord_cnt_d;
            flt_cnt_q <= flt_cnt_d;
        end
    end

    assign ord_cnt = ord_cnt_q;
    assign flt_cnt = flt_cnt_q;
`endif

endmodule
